// File: rtl/conv1_calc.sv
// Single-channel convolution engine: captures a FILTER_SIZE x FILTER_SIZE window, accumulates one row of
// products per cycle against a writable weight/bias bank, then applies ReLU, a right shift and saturation.
module conv1_calc #(
  parameter int DATA_BITS   = 8,
  parameter int FILTER_SIZE = 7,
  parameter int W_BITS      = 8,
  parameter int SHIFT       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS:0]   data_in [0:FILTER_SIZE*FILTER_SIZE-1],
  output logic                        calc_ready,
  input  logic                        w_wr_en,
  input  logic [5:0]                  w_addr,
  input  logic signed [15:0]          w_data,
  output logic                        valid_out,
  output logic [DATA_BITS-1:0]        data_out,
  input  logic                        out_ready
);

  localparam int N        = FILTER_SIZE * FILTER_SIZE;
  localparam int ACC_MIN  = DATA_BITS + 1 + W_BITS + $clog2(N) + 1;
  localparam int ACC_BITS = (ACC_MIN > 24) ? ACC_MIN : 24;
  localparam int ROW_BITS = $clog2(FILTER_SIZE + 1);
  localparam logic [5:0] BIAS_ADDR = 6'(N);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(FILTER_SIZE);
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((1 << DATA_BITS) - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                      state_q, state_d;
  logic                        armed_q;
  logic [ROW_BITS-1:0]         row_q;
  logic signed [ACC_BITS-1:0]  acc_q;
  logic signed [DATA_BITS:0]   data_q   [0:N-1];
  logic signed [W_BITS-1:0]    weight_q [0:N-1];
  logic signed [15:0]          bias_q;
  logic [DATA_BITS-1:0]        data_out_q;

  logic                        accept;
  logic [ROW_BITS-1:0]         row_idx;
  logic signed [ACC_BITS-1:0]  row_sum;
  logic signed [ACC_BITS-1:0]  total;
  logic signed [ACC_BITS-1:0]  shifted;
  logic [DATA_BITS-1:0]        result;

  assign accept = valid_in && calc_ready;

  // armed_q keeps calc_ready low until the first edge after reset releases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (row_q == LAST_ROW) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    calc_ready = (state_q == IDLE) && armed_q;
    valid_out  = (state_q == OUT);
    data_out   = data_out_q;
  end

  always_comb begin
    row_idx = (row_q < LAST_ROW) ? row_q : '0;
    row_sum = '0;
    for (int c = 0; c < FILTER_SIZE; c++) begin
      row_sum = row_sum + ACC_BITS'(data_q[int'(row_idx) * FILTER_SIZE + c])
                        * ACC_BITS'(weight_q[int'(row_idx) * FILTER_SIZE + c]);
    end
  end

  // ReLU first, so the arithmetic shift only ever sees non-negative values
  always_comb begin
    total   = acc_q + ACC_BITS'(bias_q);
    shifted = total[ACC_BITS-1] ? '0 : (total >>> SHIFT);
    result  = (shifted > SAT_MAX) ? '1 : shifted[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        weight_q[i] <= '0;
        data_q[i]   <= '0;
      end
      bias_q     <= '0;
      acc_q      <= '0;
      row_q      <= '0;
      data_out_q <= '0;
    end else begin
      if (w_wr_en && state_q == IDLE) begin
        for (int i = 0; i < N; i++) begin
          if (w_addr == 6'(i)) weight_q[i] <= w_data[W_BITS-1:0];
        end
        if (w_addr == BIAS_ADDR) bias_q <= w_data;
      end
      if (state_q == IDLE && accept) begin
        for (int i = 0; i < N; i++) data_q[i] <= data_in[i];
        acc_q <= '0;
        row_q <= '0;
      end else if (state_q == MAC) begin
        if (row_q == LAST_ROW) begin
          data_out_q <= result;
        end else begin
          acc_q <= acc_q + row_sum;
          row_q <= row_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv1_calc.sv
// Directed bench for conv1_calc: a SHIFT=8 and a SHIFT=0 instance share one stimulus stream so every
// window checks both the shifted result and the saturating path.
module tb_conv1_calc;

  localparam int DB = 8;
  localparam int FS = 7;
  localparam int N  = FS * FS;

  logic clk = 1'b0;
  logic rst;
  logic validIn, wWrEn, outReady;
  logic [5:0] wAddr;
  logic signed [15:0] wData;
  logic signed [DB:0] dataIn [0:N-1];
  logic calcReady, validOut, calcReady0, validOut0;
  logic [DB-1:0] dataOut, dataOut0;

  int checks = 0;
  int errors = 0;
  int tbW [0:N-1];
  int tbBias;

  typedef struct {
    int w;
    int b;
    int p;
    int exp8;
    int exp0;
  } vec_t;
  vec_t vecs [0:9];

  always #5 clk = ~clk;

  conv1_calc #(.DATA_BITS(DB), .FILTER_SIZE(FS), .W_BITS(8), .SHIFT(8)) dut (
    .clk(clk), .rst(rst), .valid_in(validIn), .data_in(dataIn), .calc_ready(calcReady),
    .w_wr_en(wWrEn), .w_addr(wAddr), .w_data(wData), .valid_out(validOut),
    .data_out(dataOut), .out_ready(outReady));

  conv1_calc #(.DATA_BITS(DB), .FILTER_SIZE(FS), .W_BITS(8), .SHIFT(0)) dutSat (
    .clk(clk), .rst(rst), .valid_in(validIn), .data_in(dataIn), .calc_ready(calcReady0),
    .w_wr_en(wWrEn), .w_addr(wAddr), .w_data(wData), .valid_out(validOut0),
    .data_out(dataOut0), .out_ready(outReady));

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference result for the current tbW/tbBias/dataIn contents
  function automatic int modelOut(input int shift);
    longint acc;
    acc = tbBias;
    for (int i = 0; i < N; i++) acc += longint'(dataIn[i]) * tbW[i];
    if (acc < 0) acc = 0;
    acc = acc >>> shift;
    if (acc > 255) return 255;
    return int'(acc);
  endfunction

  task automatic loadWeights();
    wWrEn = 1'b1;
    for (int i = 0; i <= N; i++) begin
      wAddr = 6'(i);
      wData = (i == N) ? 16'(tbBias) : 16'(tbW[i]);
      @(posedge clk); #1;
    end
    wWrEn = 1'b0;
  endtask

  task automatic applyStimulus(input logic accWr, input int accBias, input logic macWr,
                               output int latency, output int o8, output int o0);
    int waitCnt;
    waitCnt = 0;
    validIn = 1'b1;
    while (!calcReady && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (accWr) begin
      wWrEn = 1'b1;
      wAddr = 6'(N);
      wData = 16'(accBias);
    end
    @(posedge clk); #1;
    validIn = 1'b0;
    wWrEn = 1'b0;
    latency = -1;
    o8 = -1;
    o0 = -1;
    for (int k = 1; k <= 30; k++) begin
      if (macWr && k == 2) begin
        wWrEn = 1'b1;
        wAddr = 6'(N);
        wData = 16'sd30000;
      end else begin
        wWrEn = 1'b0;
      end
      @(posedge clk); #1;
      if (validOut) begin
        latency = k;
        o8 = int'(dataOut);
        o0 = int'(dataOut0);
        break;
      end
    end
    wWrEn = 1'b0;
  endtask

  task automatic releaseOutput();
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  task automatic setUniform(input int w, input int b, input int p);
    for (int i = 0; i < N; i++) begin
      tbW[i] = w;
      dataIn[i] = 9'(p);
    end
    tbBias = b;
  endtask

  initial begin
    int lat, o8, o0, pulses;
    vecs[0] = '{w: 0,    b: 0,     p: 10,   exp8: 0,   exp0: 0};
    vecs[1] = '{w: 1,    b: 0,     p: 10,   exp8: 1,   exp0: 255};
    vecs[2] = '{w: -1,   b: 100,   p: 10,   exp8: 0,   exp0: 0};
    vecs[3] = '{w: 2,    b: 300,   p: 5,    exp8: 3,   exp0: 255};
    vecs[4] = '{w: 1,    b: 0,     p: -3,   exp8: 0,   exp0: 0};
    vecs[5] = '{w: 0,    b: 200,   p: 1,    exp8: 0,   exp0: 200};
    vecs[6] = '{w: 127,  b: 32767, p: 255,  exp8: 255, exp0: 255};
    vecs[7] = '{w: -128, b: 0,     p: -256, exp8: 255, exp0: 255};
    vecs[8] = '{w: 3,    b: -50,   p: 2,    exp8: 0,   exp0: 244};
    vecs[9] = '{w: 1,    b: 1280,  p: 0,    exp8: 5,   exp0: 255};

    rst = 1'b1;
    validIn = 1'b0;
    wWrEn = 1'b0;
    outReady = 1'b0;
    wAddr = '0;
    wData = '0;
    setUniform(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset calc_ready", int'(calcReady), 0);
    checkOutput("reset valid_out", int'(validOut), 0);
    checkOutput("reset data_out", int'(dataOut), 0);
    rst = 1'b0;
    checkOutput("calc_ready before first edge", int'(calcReady), 0);
    @(posedge clk); #1;
    checkOutput("calc_ready after first edge", int'(calcReady), 1);

    for (int v = 0; v < 10; v++) begin
      setUniform(vecs[v].w, vecs[v].b, vecs[v].p);
      loadWeights();
      applyStimulus(1'b0, 0, 1'b0, lat, o8, o0);
      checkOutput($sformatf("vec%0d latency", v), lat, FS + 1);
      checkOutput($sformatf("vec%0d data_out shift8", v), o8, vecs[v].exp8);
      checkOutput($sformatf("vec%0d data_out shift0", v), o0, vecs[v].exp0);
      releaseOutput();
      checkOutput($sformatf("vec%0d valid_out after release", v), int'(validOut), 0);
      checkOutput($sformatf("vec%0d calc_ready after release", v), int'(calcReady), 1);
    end

    // Non-uniform weights and pixels expose row/column ordering errors
    for (int i = 0; i < N; i++) begin
      tbW[i] = (i % 5) - 2;
      dataIn[i] = 9'((i % 7) * 3 - 4);
    end
    tbBias = 500;
    loadWeights();
    applyStimulus(1'b0, 0, 1'b0, lat, o8, o0);
    checkOutput("pattern data_out shift8", o8, modelOut(8));
    checkOutput("pattern data_out shift0", o0, modelOut(0));
    releaseOutput();

    // Bias write on the accept edge is used; bias write during MAC is dropped
    setUniform(1, 0, 10);
    loadWeights();
    applyStimulus(1'b1, 1280, 1'b1, lat, o8, o0);
    checkOutput("same-edge bias write", o8, 6);
    releaseOutput();
    applyStimulus(1'b0, 0, 1'b0, lat, o8, o0);
    checkOutput("bias write during MAC ignored", o8, 6);
    releaseOutput();

    // Backpressure with valid_in held high and a different window presented
    setUniform(1, 0, 10);
    loadWeights();
    applyStimulus(1'b0, 0, 1'b0, lat, o8, o0);
    checkOutput("backpressure first result", o8, 1);
    for (int i = 0; i < N; i++) dataIn[i] = 9'sd20;
    validIn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d valid_out", k), int'(validOut), 1);
      checkOutput($sformatf("stall%0d data_out", k), int'(dataOut), 1);
      checkOutput($sformatf("stall%0d calc_ready", k), int'(calcReady), 0);
    end
    releaseOutput();
    checkOutput("backpressure release valid_out", int'(validOut), 0);
    checkOutput("backpressure release calc_ready", int'(calcReady), 1);
    applyStimulus(1'b0, 0, 1'b0, lat, o8, o0);
    checkOutput("backpressure next window latency", lat, FS + 1);
    checkOutput("backpressure next window data_out", o8, 3);
    releaseOutput();

    // Reset three edges into MAC: no result, weights wiped
    for (int i = 0; i < N; i++) dataIn[i] = 9'sd10;
    validIn = 1'b1;
    @(posedge clk); #1;
    validIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid-MAC reset calc_ready", int'(calcReady), 0);
    checkOutput("mid-MAC reset data_out", int'(dataOut), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (validOut) pulses++;
    end
    checkOutput("no valid_out after reset", pulses, 0);
    checkOutput("calc_ready after mid-MAC reset", int'(calcReady), 1);
    applyStimulus(1'b0, 0, 1'b0, lat, o8, o0);
    checkOutput("post-reset latency", lat, FS + 1);
    checkOutput("post-reset zero weights shift8", o8, 0);
    checkOutput("post-reset zero weights shift0", o0, 0);
    releaseOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
